mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
- Iterative HI/LO multiply/divide unit in the EX stage of the 5-stage MIPS pipeline.
- Executes MULT/MULTU/DIV/DIVU/MTHI/MTLO and holds the architectural HI/LO registers.
- Raises `stall_req` while busy; this drives the pipeline controller's `mulalu` input.
- Takes the controller's exception flush and EX hold back as inputs, so it never commits HI/LO for a squashed or replayed instruction.

Parameters:
- MUL_LAT, 2, number of multiply compute cycles (1..8); the product is formed over this many cycles.

Ports:
- clk  input  1  clock, rising edge.
- resetn  input  1  asynchronous active-low reset.
- op_valid  input  1  EX-stage instruction is a HI/LO op.
- op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110 and 111 are ignored.
- src_a  input  32  rs operand.
- src_b  input  32  rt operand.
- flush  input  1  exception flush of EX (controller `except`).
- ex_hold  input  1  EX held by another stall source (controller `id_ex_stall`).
- stall_req  output  1  to controller `mulalu`.
- hi  output  32  architectural HI, registered.
- lo  output  32  architectural LO, registered.
- busy  output  1  state is not IDLE.

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE, counter=0, hi=0, lo=0.
  - stall_req=0, busy=0.
  - Internal result and operand registers are cleared.
- States:
  - IDLE: no operation in progress.
  - MUL: multiply compute.
  - DIV: divide compute.
  - DONE: result ready, awaiting commit.
- stall_req:
  - = !flush & (state==MUL | state==DIV | (state==IDLE & op_valid & op∈{MULT,MULTU,DIV,DIVU})).
  - Must not depend combinationally on ex_hold; this avoids a loop through the controller.
- IDLE, mul/div op (op_valid & !flush):
  - Latch src_a/src_b and the signedness.
  - MULT/MULTU: go to MUL with counter=MUL_LAT-1.
  - DIV/DIVU with src_b≠0: go to DIV with counter=31.
  - DIV/DIVU with src_b==0: go directly to DONE with a no-write flag set.
- MUL: decrement the counter each cycle.
  - At counter==0, form the 64-bit product and go to DONE.
  - MULTU: unsigned 32x32 product.
  - MULT: two's-complement product.
  - Result hi = product[63:32], lo = product[31:0].
- DIV: restoring radix-2 on magnitudes, one quotient bit per cycle, 32 cycles.
  - Then go to DONE with quotient→lo, remainder→hi.
  - Signed fix-up: quotient negated iff sign(a)^sign(b); remainder takes the sign of a.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- Divide by zero: HI/LO are left unchanged; there is no trap.
- DONE: stall_req=0 and the instruction may leave EX.
  - If flush: go to IDLE without committing.
  - Else if ex_hold: remain in DONE; commit is deferred.
  - Else: commit the result to hi/lo (unless no-write) at the clock edge and go to IDLE.
- Timing and latency:
  - An MFHI in EX on the next cycle reads the new value.
  - MULT/MULTU: stall_req is high for MUL_LAT+1 cycles.
  - DIV/DIVU: stall_req is high for 33 cycles.
  - Divide by zero: stall_req is high for 1 cycle.
  - In every case, DONE is one further cycle.
- MTHI/MTLO in IDLE with op_valid & !flush & !ex_hold: write src_a to hi (or lo) at the edge. These ops never stall.
- flush in MUL or DIV: abort to IDLE next cycle. stall_req is 0 in the flush cycle; hi/lo are unchanged.
- op_valid is ignored outside IDLE: no restart while the held instruction sits in EX.
- Reset asserted mid-operation: returns to the reset state immediately and discards any partial result.
- busy=1 in MUL, DIV and DONE.

Test Plan:
- MULTU 0xFFFFFFFF×0xFFFFFFFF, MUL_LAT=2 → stall_req high for 3 cycles, DONE 1 cycle; then hi=0xFFFFFFFE, lo=0x00000001.
- MULT 0xFFFFFFFE(−2)×0x00000003 → hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- DIV 0xFFFFFFF9(−7)/0x00000002 → stall_req high for 33 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 → lo=3, hi=1.
- DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0. DIVU 5/0 → stall_req 1 cycle, hi/lo keep their prior values.
- Start DIV, assert flush at cycle 10 → stall_req=0 that cycle, state IDLE next cycle, hi/lo unchanged. Flush during DONE → no commit.
- MULT reaches DONE with ex_hold=1 for 3 cycles → stays in DONE, no repeat start; commits on the first ex_hold=0 edge. MTLO 0x1234 with ex_hold=0 → lo=0x1234 next cycle, stall_req never set.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative HI/LO multiply/divide unit for the EX stage: owns the architectural HI/LO
// registers and stalls the pipeline while a MULT/DIV is in flight.
module mul_div_unit #(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    input  logic        ex_hold,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t      r_state, w_next;
    logic [4:0]  r_cnt;
    logic [31:0] r_a, r_b, r_rem, r_quo;
    logic [31:0] r_resHi, r_resLo, r_hi, r_lo;
    logic        r_signed, r_negQ, r_negR, r_noWrite;

    logic        w_mulDivOp, w_isMul, w_sgn, w_start, w_commit, w_mtWrite;
    logic [31:0] w_magA, w_magB, w_sub, w_remNext, w_quoNext;
    logic [32:0] w_shift;
    logic        w_ge;
    logic [63:0] w_prod;

    assign w_mulDivOp = op_valid & ~op[2];
    assign w_isMul    = ~op[1];
    assign w_sgn      = ~op[0];
    assign w_start    = (r_state == S_IDLE) & w_mulDivOp & ~flush;
    assign w_commit   = (r_state == S_DONE) & ~flush & ~ex_hold & ~r_noWrite;
    assign w_mtWrite  = (r_state == S_IDLE) & op_valid & ~flush & ~ex_hold;

    assign w_magA = (w_sgn & src_a[31]) ? (32'd0 - src_a) : src_a;
    assign w_magB = (w_sgn & src_b[31]) ? (32'd0 - src_b) : src_b;

    // Sign/zero-extend to 64 bits so the low 64 bits of the product suit both MULT and MULTU.
    assign w_prod = {{32{r_signed & r_a[31]}}, r_a} * {{32{r_signed & r_b[31]}}, r_b};

    // One restoring step: r_quo shifts the dividend out at the top and quotient bits in at the bottom.
    assign w_shift   = {r_rem, r_quo[31]};
    assign w_ge      = w_shift >= {1'b0, r_b};
    assign w_sub     = w_shift[31:0] - r_b;
    assign w_remNext = w_ge ? w_sub : w_shift[31:0];
    assign w_quoNext = {r_quo[30:0], w_ge};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_start) w_next = w_isMul ? S_MUL : ((src_b == 32'd0) ? S_DONE : S_DIV);
            S_MUL, S_DIV: begin
                if (flush)                w_next = S_IDLE;
                else if (r_cnt == 5'd0)   w_next = S_DONE;
            end
            S_DONE: if (flush || !ex_hold) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        stall_req = ~flush & ((r_state == S_MUL) | (r_state == S_DIV) |
                              ((r_state == S_IDLE) & w_mulDivOp));
        busy      = (r_state != S_IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt     <= 5'd0;
            r_a       <= 32'd0;
            r_b       <= 32'd0;
            r_rem     <= 32'd0;
            r_quo     <= 32'd0;
            r_resHi   <= 32'd0;
            r_resLo   <= 32'd0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_signed  <= 1'b0;
            r_negQ    <= 1'b0;
            r_negR    <= 1'b0;
            r_noWrite <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_signed  <= w_sgn;
                        r_negQ    <= w_sgn & (src_a[31] ^ src_b[31]);
                        r_negR    <= w_sgn & src_a[31];
                        r_rem     <= 32'd0;
                        if (w_isMul) begin
                            r_a       <= src_a;
                            r_b       <= src_b;
                            r_cnt     <= 5'(MUL_LAT - 1);
                            r_noWrite <= 1'b0;
                        end else begin
                            r_quo     <= w_magA;
                            r_b       <= w_magB;
                            r_cnt     <= 5'd31;
                            r_noWrite <= (src_b == 32'd0);
                        end
                    end else if (w_mtWrite && op == 3'b100) begin
                        r_hi <= src_a;
                    end else if (w_mtWrite && op == 3'b101) begin
                        r_lo <= src_a;
                    end
                end
                S_MUL: begin
                    if (!flush) begin
                        if (r_cnt != 5'd0) r_cnt <= r_cnt - 5'd1;
                        else begin
                            r_resHi <= w_prod[63:32];
                            r_resLo <= w_prod[31:0];
                        end
                    end
                end
                S_DIV: begin
                    if (!flush) begin
                        r_rem <= w_remNext;
                        r_quo <= w_quoNext;
                        if (r_cnt != 5'd0) r_cnt <= r_cnt - 5'd1;
                        else begin
                            r_resLo <= r_negQ ? (32'd0 - w_quoNext) : w_quoNext;
                            r_resHi <= r_negR ? (32'd0 - w_remNext) : w_remNext;
                        end
                    end
                end
                S_DONE: begin
                    if (w_commit) begin
                        r_hi <= r_resHi;
                        r_lo <= r_resLo;
                    end
                end
                default: ;
            endcase
        end
    end

    assign hi = r_hi;
    assign lo = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: a constant vector table, a random run against
// an arithmetic reference model, and hand-built flush/hold/reset sequences.
module tb_mul_div_unit;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        resetn, op_valid, flush, ex_hold;
    logic [2:0]  op;
    logic [31:0] src_a, src_b;
    logic        stall_req, busy;
    logic [31:0] hi, lo;

    int total = 0;
    int bad   = 0;
    logic [31:0] mHi, mLo;

    always #5 clk = ~clk;

    mul_div_unit #(.MUL_LAT(LAT)) dut (
        .clk(clk), .resetn(resetn), .op_valid(op_valid), .op(op),
        .src_a(src_a), .src_b(src_b), .flush(flush), .ex_hold(ex_hold),
        .stall_req(stall_req), .hi(hi), .lo(lo), .busy(busy)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expHi;
        logic [31:0] expLo;
        int          expStall;
    } vec_t;

    vec_t vecs[12];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Architectural result of a HI/LO op computed with plain arithmetic.
    task automatic refModel(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                            inout logic [31:0] h, inout logic [31:0] l);
        longint      sa, sb, sp, sq, sr;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            3'd0: begin sp = sa * sb; h = sp[63:32]; l = sp[31:0]; end
            3'd1: begin up = {32'd0, a} * {32'd0, b}; h = up[63:32]; l = up[31:0]; end
            3'd2: if (b != 32'd0) begin sq = sa / sb; sr = sa % sb; l = sq[31:0]; h = sr[31:0]; end
            3'd3: if (b != 32'd0) begin l = a / b; h = a % b; end
            3'd4: h = a;
            3'd5: l = a;
            default: ;
        endcase
    endtask

    function automatic int expStall(input logic [2:0] o, input logic [31:0] b);
        if (o == 3'd0 || o == 3'd1) return LAT + 1;
        if (o == 3'd2 || o == 3'd3) return (b == 32'd0) ? 1 : 33;
        return 0;
    endfunction

    // Presents an op in EX and returns once stall_req drops (DONE, or the MT/ignored cycle).
    task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                 output int stalls, output logic doneBusy);
        @(negedge clk);
        op_valid = 1'b1; op = o; src_a = a; src_b = b;
        stalls = 0;
        #1;
        while (stall_req === 1'b1 && stalls < 100) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        doneBusy = busy;
    endtask

    task automatic finishOp();
        @(negedge clk);
        op_valid = 1'b0;
        #1;
    endtask

    task automatic runChecked(input string tag, input logic [2:0] o, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] eHi, input logic [31:0] eLo,
                              input int eStall);
        int   stalls;
        logic db;
        applyStimulus(o, a, b, stalls, db);
        checkOutput({tag, " stall"}, 64'(stalls), 64'(eStall));
        checkOutput({tag, " busyDone"}, 64'(db), 64'(o[2] == 1'b0));
        finishOp();
        checkOutput({tag, " hi"}, 64'(hi), 64'(eHi));
        checkOutput({tag, " lo"}, 64'(lo), 64'(eLo));
        checkOutput({tag, " idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int   stalls;
        logic db;
        logic [2:0]  ro;
        logic [31:0] ra, rb;

        vecs[0]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 3};
        vecs[1]  = '{3'd0, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 3};
        vecs[2]  = '{3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33};
        vecs[3]  = '{3'd3, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 33};
        vecs[4]  = '{3'd3, 32'h00000005, 32'h00000000, 32'h00000001, 32'h00000003, 1};
        vecs[5]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33};
        vecs[6]  = '{3'd5, 32'h00001234, 32'h00000000, 32'h00000000, 32'h00001234, 0};
        vecs[7]  = '{3'd4, 32'hA5A5A5A5, 32'h00000000, 32'hA5A5A5A5, 32'h00001234, 0};
        vecs[8]  = '{3'd2, 32'h00000000, 32'h00000000, 32'hA5A5A5A5, 32'h00001234, 1};
        vecs[9]  = '{3'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33};
        vecs[10] = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 3};
        vecs[11] = '{3'd6, 32'hDEADBEEF, 32'h00000001, 32'h40000000, 32'h00000000, 0};

        resetn = 1'b0; op_valid = 1'b0; flush = 1'b0; ex_hold = 1'b0;
        op = 3'd0; src_a = 32'd0; src_b = 32'd0;
        #12;
        checkOutput("reset hi", 64'(hi), 64'd0);
        checkOutput("reset lo", 64'(lo), 64'd0);
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset stall", 64'(stall_req), 64'd0);
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < 12; i++)
            runChecked($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                       vecs[i].expHi, vecs[i].expLo, vecs[i].expStall);

        mHi = 32'h40000000;
        mLo = 32'h00000000;
        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 5));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 9));
            refModel(ro, ra, rb, mHi, mLo);
            runChecked($sformatf("rand%0d op%0d", i, ro), ro, ra, rb, mHi, mLo, expStall(ro, rb));
        end

        // Flush on the tenth stall cycle of a DIV.
        @(negedge clk);
        op_valid = 1'b1; op = 3'd2; src_a = 32'd1000; src_b = 32'd7;
        for (int c = 0; c < 9; c++) @(negedge clk);
        flush = 1'b1;
        #1;
        checkOutput("divFlush stall", 64'(stall_req), 64'd0);
        checkOutput("divFlush busy", 64'(busy), 64'd1);
        @(negedge clk);
        flush = 1'b0; op_valid = 1'b0;
        #1;
        checkOutput("divFlush idle", 64'(busy), 64'd0);
        checkOutput("divFlush hi", 64'(hi), 64'(mHi));
        checkOutput("divFlush lo", 64'(lo), 64'(mLo));

        // Flush arriving while the result waits in DONE.
        applyStimulus(3'd1, 32'h12345678, 32'h9, stalls, db);
        checkOutput("doneFlush stall", 64'(stalls), 64'(LAT + 1));
        flush = 1'b1;
        #1;
        checkOutput("doneFlush stallLow", 64'(stall_req), 64'd0);
        @(negedge clk);
        flush = 1'b0; op_valid = 1'b0;
        #1;
        checkOutput("doneFlush idle", 64'(busy), 64'd0);
        checkOutput("doneFlush hi", 64'(hi), 64'(mHi));
        checkOutput("doneFlush lo", 64'(lo), 64'(mLo));

        // ex_hold keeps the result parked in DONE until released.
        applyStimulus(3'd0, 32'hFFFFFFF0, 32'h00000011, stalls, db);
        checkOutput("hold stall", 64'(stalls), 64'(LAT + 1));
        ex_hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            checkOutput($sformatf("hold%0d busy", k), 64'(busy), 64'd1);
            checkOutput($sformatf("hold%0d stall", k), 64'(stall_req), 64'd0);
            checkOutput($sformatf("hold%0d hi", k), 64'(hi), 64'(mHi));
        end
        ex_hold = 1'b0;
        refModel(3'd0, 32'hFFFFFFF0, 32'h00000011, mHi, mLo);
        finishOp();
        checkOutput("hold commit hi", 64'(hi), 64'(mHi));
        checkOutput("hold commit lo", 64'(lo), 64'(mLo));
        checkOutput("hold idle", 64'(busy), 64'd0);

        // MTLO blocked while EX is held.
        ex_hold = 1'b1;
        applyStimulus(3'd5, 32'h0000BEEF, 32'd0, stalls, db);
        checkOutput("mtHold stall", 64'(stalls), 64'd0);
        @(negedge clk);
        op_valid = 1'b0; ex_hold = 1'b0;
        #1;
        checkOutput("mtHold lo", 64'(lo), 64'(mLo));

        // Reset asserted in the middle of a divide.
        @(negedge clk);
        op_valid = 1'b1; op = 3'd3; src_a = 32'd100; src_b = 32'd3;
        repeat (5) @(negedge clk);
        #2;
        resetn = 1'b0; op_valid = 1'b0;
        #1;
        checkOutput("midReset busy", 64'(busy), 64'd0);
        checkOutput("midReset hi", 64'(hi), 64'd0);
        checkOutput("midReset lo", 64'(lo), 64'd0);
        checkOutput("midReset stall", 64'(stall_req), 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        runChecked("postReset", 3'd3, 32'd100, 32'd3, 32'd1, 32'd33, 33);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
